// File: rtl/spi_reg_ctrl.sv
// spi_reg_ctrl: SPI mode-0 target plus the five PWM-stage control registers.
// SCLK/COPI/nCS are oversampled in the i_clk domain; 16-bit frames are
// decoded as {R/W, addr[6:0], data[7:0]}, MSB first. Malformed frames are
// discarded with a one-cycle o_frame_err pulse.
// Optional feature macro: SPI_READBACK_EN (register readback on o_cipo).
module spi_reg_ctrl #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned MAX_ADDR    = 4
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_sclk,
    input  logic       i_copi,
    input  logic       i_ncs,
    output logic       o_cipo,
    output logic [7:0] o_en_reg_out_7_0,
    output logic [7:0] o_en_reg_out_15_8,
    output logic [7:0] o_en_reg_pwm_7_0,
    output logic [7:0] o_en_reg_pwm_15_8,
    output logic [7:0] o_pwm_duty_cycle,
    output logic       o_frame_err
);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        COMMIT
    } state_t;

    localparam logic [6:0] MaxAddr = 7'(MAX_ADDR);
    localparam logic [4:0] CntFull = 5'd16;
    localparam logic [4:0] CntOvf  = 5'd17;

    // Synchronizer chains and edge-detect history
    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_copi_sync;
    logic [SYNC_STAGES-1:0] r_ncs_sync;
    logic [SYNC_STAGES-1:0] r_fill;
    logic                   r_sclk_prev;
    logic                   r_ncs_prev;
    logic                   r_armed;

    logic w_sclk_s;
    logic w_copi_s;
    logic w_ncs_s;
    logic w_sclk_rise;
    logic w_ncs_rise;
    logic w_ncs_fall;

    // Frame state
    state_t      r_state;
    state_t      w_state_next;
    logic [15:0] r_shift;
    logic [4:0]  r_cnt;
    logic [15:0] w_shift_next;
    logic [4:0]  w_cnt_next;
    logic        w_frame_start;
    logic        w_shift_en;
    logic        w_frame_end;
    logic [6:0]  w_addr;
    logic        w_wr_en;
    logic        w_read_ok;
    logic        w_err;

    // Register bank
    logic [7:0] r_reg0;
    logic [7:0] r_reg1;
    logic [7:0] r_reg2;
    logic [7:0] r_reg3;
    logic [7:0] r_reg4;
    logic       r_frame_err;

    // Pin synchronizers; sclk idles low and ncs idles high so reset release is edge-free
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_sync <= '0;
            r_copi_sync <= '0;
            r_ncs_sync  <= '1;
            r_fill      <= '0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], i_sclk};
            r_copi_sync <= {r_copi_sync[SYNC_STAGES-2:0], i_copi};
            r_ncs_sync  <= {r_ncs_sync[SYNC_STAGES-2:0], i_ncs};
            r_fill      <= {r_fill[SYNC_STAGES-2:0], 1'b1};
        end
    end

    assign w_sclk_s = r_sclk_sync[SYNC_STAGES-1];
    assign w_copi_s = r_copi_sync[SYNC_STAGES-1];
    assign w_ncs_s  = r_ncs_sync[SYNC_STAGES-1];

    // Previous synced values for edge detection; r_armed needs a real ncs-high sample
    // after reset so a frame already in progress at reset release is never picked up
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sclk_prev <= 1'b0;
            r_ncs_prev  <= 1'b1;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_prev <= w_sclk_s;
            r_ncs_prev  <= w_ncs_s;
            if (r_fill[SYNC_STAGES-1] && w_ncs_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    assign w_sclk_rise = w_sclk_s & ~r_sclk_prev;
    assign w_ncs_rise  = w_ncs_s & ~r_ncs_prev;
    assign w_ncs_fall  = ~w_ncs_s & r_ncs_prev & r_armed;

    // Frame control: ncs rise beats a same-cycle sclk rise
    assign w_frame_start = (r_state == IDLE) & w_ncs_fall;
    assign w_shift_en    = (r_state == SHIFT) & w_sclk_rise & ~w_ncs_rise;
    assign w_frame_end   = (r_state == SHIFT) & w_ncs_rise;
    assign w_shift_next  = {r_shift[14:0], w_copi_s};
    assign w_cnt_next    = (r_cnt == CntOvf) ? r_cnt : r_cnt + 5'd1;
    assign w_addr        = r_shift[14:8];

    // The commit decision is taken on the SHIFT->COMMIT edge so the write lands
    // SYNC_STAGES+1 clocks after the pin rises; COMMIT carries the error pulse.
    assign w_wr_en = w_frame_end & (r_cnt == CntFull) & r_shift[15] & (w_addr <= MaxAddr);
    assign w_err   = w_frame_end & ~w_wr_en & ~w_read_ok;

    // FSM state register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // FSM next-state logic
    always_comb begin
        w_state_next = r_state;
        unique case (r_state)
            IDLE:    if (w_ncs_fall) w_state_next = SHIFT;
            SHIFT:   if (w_ncs_rise) w_state_next = COMMIT;
            COMMIT:  w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Shift register and saturating bit counter (17 = overflow)
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_frame_start) begin
            r_shift <= '0;
            r_cnt   <= '0;
        end else if (w_shift_en) begin
            r_shift <= w_shift_next;
            r_cnt   <= w_cnt_next;
        end
    end

    // Register bank write; only a well-formed write frame touches it
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_reg0 <= '0;
            r_reg1 <= '0;
            r_reg2 <= '0;
            r_reg3 <= '0;
            r_reg4 <= '0;
        end else if (w_wr_en) begin
            case (w_addr)
                7'd0:    r_reg0 <= r_shift[7:0];
                7'd1:    r_reg1 <= r_shift[7:0];
                7'd2:    r_reg2 <= r_shift[7:0];
                7'd3:    r_reg3 <= r_shift[7:0];
                7'd4:    r_reg4 <= r_shift[7:0];
                default: ;
            endcase
        end
    end

    // Discarded-frame pulse, high for the single COMMIT cycle
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_frame_err <= 1'b0;
        end else begin
            r_frame_err <= w_err;
        end
    end

`ifdef SPI_READBACK_EN
    logic       w_sclk_fall;
    logic       w_rd_load;
    logic [6:0] w_rd_addr;
    logic [7:0] w_rd_data;
    logic [7:0] r_tx;
    logic       r_cipo;

    assign w_sclk_fall = ~w_sclk_s & r_sclk_prev;
    // Eighth bit in with R/W = 0: the address byte is complete
    assign w_rd_load   = w_shift_en & (r_cnt == 5'd7) & ~w_shift_next[7];
    assign w_rd_addr   = w_shift_next[6:0];
    assign w_read_ok   = w_frame_end & (r_cnt == CntFull) & ~r_shift[15];

    // Readback mux; out-of-range addresses return 0x00
    always_comb begin
        w_rd_data = 8'h00;
        if (w_rd_addr <= MaxAddr) begin
            case (w_rd_addr)
                7'd0:    w_rd_data = r_reg0;
                7'd1:    w_rd_data = r_reg1;
                7'd2:    w_rd_data = r_reg2;
                7'd3:    w_rd_data = r_reg3;
                7'd4:    w_rd_data = r_reg4;
                default: w_rd_data = 8'h00;
            endcase
        end
    end

    // Output shifter: r_cipo takes bit7 on each sclk fall so data is stable at the next rise
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_frame_start || w_ncs_rise) begin
            r_tx   <= '0;
            r_cipo <= 1'b0;
        end else if (w_rd_load) begin
            r_tx <= w_rd_data;
        end else if ((r_state == SHIFT) && w_sclk_fall) begin
            r_cipo <= r_tx[7];
            r_tx   <= {r_tx[6:0], 1'b0};
        end
    end

    assign o_cipo = r_cipo;
`else
    assign w_read_ok = 1'b0;
    assign o_cipo    = 1'b0;
`endif

    assign o_en_reg_out_7_0  = r_reg0;
    assign o_en_reg_out_15_8 = r_reg1;
    assign o_en_reg_pwm_7_0  = r_reg2;
    assign o_en_reg_pwm_15_8 = r_reg3;
    assign o_pwm_duty_cycle  = r_reg4;
    assign o_frame_err       = r_frame_err;

endmodule

// File: tb/tb_spi_reg_ctrl.sv
// Directed bench for spi_reg_ctrl: write decode, timing, malformed frames,
// read frames (with or without SPI_READBACK_EN) and mid-frame reset.
module tb_spi_reg_ctrl;

    localparam int H = 6;  // SPI half-period in clk cycles

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk;
    logic       copi;
    logic       ncs;
    logic       cipo;
    logic [7:0] reg0, reg1, reg2, reg3, reg4;
    logic       frame_err;

    int          n_total = 0;
    int          n_bad   = 0;
    int          err_pulses = 0;
    int          e0;
    logic [31:0] rx;

    always #5 clk = ~clk;

    spi_reg_ctrl #(
        .SYNC_STAGES(2),
        .MAX_ADDR   (4)
    ) u_dut (
        .i_clk            (clk),
        .i_rst_n          (rst_n),
        .i_sclk           (sclk),
        .i_copi           (copi),
        .i_ncs            (ncs),
        .o_cipo           (cipo),
        .o_en_reg_out_7_0 (reg0),
        .o_en_reg_out_15_8(reg1),
        .o_en_reg_pwm_7_0 (reg2),
        .o_en_reg_pwm_15_8(reg3),
        .o_pwm_duty_cycle (reg4),
        .o_frame_err      (frame_err)
    );

    // Count frame_err pulses away from the active edge
    always @(negedge clk) begin
        if (frame_err) err_pulses++;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Drop ncs and send nbits of val MSB first; ncs is left low
    task automatic spi_bits(input logic [16:0] val, input int nbits);
        @(negedge clk);
        ncs = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = nbits - 1; i >= 0; i--) begin
            copi = val[i];
            repeat (H) @(negedge clk);
            rx = {rx[30:0], cipo};
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
        end
        repeat (H) @(negedge clk);
    endtask

    task automatic spi_end();
        @(negedge clk);
        ncs = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        sclk  = 1'b0;
        copi  = 1'b0;
        ncs   = 1'b1;
        rx    = '0;
        repeat (3) @(negedge clk);
        check_eq("rst_reg0", 32'(reg0), 32'h00);
        check_eq("rst_reg1", 32'(reg1), 32'h00);
        check_eq("rst_reg2", 32'(reg2), 32'h00);
        check_eq("rst_reg3", 32'(reg3), 32'h00);
        check_eq("rst_reg4", 32'(reg4), 32'h00);
        check_eq("rst_cipo", 32'(cipo), 32'h0);
        check_eq("rst_ferr", 32'(frame_err), 32'h0);
        rst_n = 1'b1;
        repeat (6) @(negedge clk);

        // Write addr 0 = 0xFF
        e0 = err_pulses;
        spi_bits(17'h080FF, 16);
        spi_end();
        check_eq("w0_reg0", 32'(reg0), 32'hFF);
        check_eq("w0_reg1", 32'(reg1), 32'h00);
        check_eq("w0_reg4", 32'(reg4), 32'h00);
        check_eq("w0_err", 32'(err_pulses - e0), 32'd0);

        // Write addr 4 = 0x80, update lands on the 3rd clk edge after ncs rises
        spi_bits(17'h08480, 16);
        @(negedge clk);
        ncs = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1 check_eq("duty_edge2", 32'(reg4), 32'h00);
        @(posedge clk);
        #1 check_eq("duty_edge3", 32'(reg4), 32'h80);
        repeat (10) @(negedge clk);

        // Address 5 is out of range
        e0 = err_pulses;
        spi_bits(17'h085AA, 16);
        spi_end();
        check_eq("bad_addr_reg0", 32'(reg0), 32'hFF);
        check_eq("bad_addr_reg4", 32'(reg4), 32'h80);
        check_eq("bad_addr_err", 32'(err_pulses - e0), 32'd1);

        // 15-bit and 17-bit frames to addr 0
        e0 = err_pulses;
        spi_bits(17'h04008, 15);
        spi_end();
        check_eq("len15_reg0", 32'(reg0), 32'hFF);
        check_eq("len15_err", 32'(err_pulses - e0), 32'd1);
        e0 = err_pulses;
        spi_bits(17'h10023, 17);
        spi_end();
        check_eq("len17_reg0", 32'(reg0), 32'hFF);
        check_eq("len17_err", 32'(err_pulses - e0), 32'd1);

        // Read of addr 4
        e0 = err_pulses;
        rx = '0;
        spi_bits(17'h00400, 16);
        spi_end();
`ifdef SPI_READBACK_EN
        check_eq("rd_cipo", 32'(rx[7:0]), 32'h80);
        check_eq("rd_err", 32'(err_pulses - e0), 32'd0);
`else
        check_eq("rd_cipo", 32'(rx[15:0]), 32'h0000);
        check_eq("rd_err", 32'(err_pulses - e0), 32'd1);
`endif
        check_eq("rd_reg4", 32'(reg4), 32'h80);
        check_eq("rd_reg0", 32'(reg0), 32'hFF);
        check_eq("post_rd_cipo", 32'(cipo), 32'h0);

        // sclk toggling with ncs high is ignored; then a normal write
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            sclk = 1'b1;
            repeat (H) @(negedge clk);
            sclk = 1'b0;
            repeat (H) @(negedge clk);
        end
        e0 = err_pulses;
        spi_bits(17'h08255, 16);
        spi_end();
        check_eq("w2_reg2", 32'(reg2), 32'h55);
        check_eq("w2_reg3", 32'(reg3), 32'h00);
        check_eq("w2_err", 32'(err_pulses - e0), 32'd0);

        // Reset after 9 bits of a write to addr 1
        spi_bits(17'h00102, 9);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check_eq("mid_rst_reg0", 32'(reg0), 32'h00);
        check_eq("mid_rst_reg2", 32'(reg2), 32'h00);
        check_eq("mid_rst_reg4", 32'(reg4), 32'h00);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        e0 = err_pulses;
        spi_bits(17'h00022, 7);
        spi_end();
        check_eq("tail_reg1", 32'(reg1), 32'h00);
        check_eq("tail_err", 32'(err_pulses - e0), 32'd0);
        spi_bits(17'h08133, 16);
        spi_end();
        check_eq("after_rst_reg1", 32'(reg1), 32'h33);
        check_eq("after_rst_reg0", 32'(reg0), 32'h00);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
